// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the seven-segment update controller.
//   - seg_state_t : controller FSM encodings (IDLE / WAIT_DONE)
//   - DEC_MAX / HEX_MAX : largest values the six-digit display can show
//   - DIGITS : number of display digits
//   - clamp_value : saturates a value to the display range, flags overflow
package seg_pkg;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_DONE = 1'b1
  } seg_state_t;

  localparam int          DIGITS  = 6;
  localparam logic [31:0] DEC_MAX = 32'd999_999;
  localparam logic [31:0] HEX_MAX = 32'h00FF_FFFF;

  // Returns {overflow, value}; base=1 selects the decimal range.
  function automatic logic [32:0] clamp_value(input logic [31:0] data,
                                              input logic        base);
    logic [31:0] limit;
    limit = base ? DEC_MAX : HEX_MAX;
    if (data > limit) clamp_value = {1'b1, limit};
    else              clamp_value = {1'b0, data};
  endfunction

endpackage

// File: rtl/seg_interval_timer.sv
// seg_interval_timer: loadable down counter that stops at zero.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this cycle (wins over decrement)
//   load_val   : reload value
//   ivl_ok     : counter has reached zero
module seg_interval_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         ivl_ok
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign ivl_ok = (cnt_reg == '0);

endmodule

// File: rtl/seg_update_ctrl.sv
// seg_update_ctrl: feeds value updates to the six-digit seven-segment display.
// Keeps a one-deep latest-value-wins buffer, rate-limits writes to one per
// MIN_INTERVAL cycles, counts overwritten updates and aborts a write whose
// done pulse never arrives.
//   in_data/in_base/in_valid : application update (always accepted)
//   force_upd                : next issue ignores the interval ("force" is a
//                              reserved word, hence the name)
//   seg_data/seg_base/seg_wen: display write port; seg_rdy/seg_done back
//   busy        : waiting for display done
//   drop_cnt    : saturating count of updates overwritten before issue
//   timeout_err : sticky, set when done never arrives
//   ovf         : pulses with seg_wen when the value was clamped
// Build option: define SEG_UPD_CLAMP_EN to clamp out-of-range values at issue.
module seg_update_ctrl
  import seg_pkg::*;
#(
  parameter logic [23:0] MIN_INTERVAL = 24'd4_999_999,
  parameter logic [15:0] DONE_TIMEOUT = 16'd1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic        in_base,
  input  logic        in_valid,
  input  logic        force_upd,
  output logic [31:0] seg_data,
  output logic        seg_base,
  output logic        seg_wen,
  input  logic        seg_rdy,
  input  logic        seg_done,
  output logic        busy,
  output logic [15:0] drop_cnt,
  output logic        timeout_err,
  output logic        ovf
);

  seg_state_t  state_reg, state_next;
  logic [31:0] pend_data_reg, pend_data_next;
  logic        pend_base_reg, pend_base_next;
  logic        pend_vld_reg, pend_vld_next;
  logic        force_pend_reg, force_pend_next;
  logic [15:0] to_cnt_reg, to_cnt_next;
  logic [31:0] seg_data_reg, seg_data_next;
  logic        seg_base_reg, seg_base_next;
  logic        seg_wen_next, busy_next, ovf_next, timeout_err_next;
  logic        seg_wen_reg, busy_reg, ovf_reg, timeout_err_reg;
  logic [15:0] drop_cnt_reg, drop_cnt_next;
  logic        ivl_ok, issue;
  logic [31:0] issue_data;
  logic        issue_ovf;

  seg_interval_timer #(.W(24)) u_ivl (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (issue),
    .load_val (MIN_INTERVAL),
    .ivl_ok   (ivl_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      pend_data_reg   <= '0;
      pend_base_reg   <= 1'b0;
      pend_vld_reg    <= 1'b0;
      force_pend_reg  <= 1'b0;
      to_cnt_reg      <= '0;
      seg_data_reg    <= '0;
      seg_base_reg    <= 1'b0;
      seg_wen_reg     <= 1'b0;
      busy_reg        <= 1'b0;
      drop_cnt_reg    <= '0;
      timeout_err_reg <= 1'b0;
      ovf_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pend_data_reg   <= pend_data_next;
      pend_base_reg   <= pend_base_next;
      pend_vld_reg    <= pend_vld_next;
      force_pend_reg  <= force_pend_next;
      to_cnt_reg      <= to_cnt_next;
      seg_data_reg    <= seg_data_next;
      seg_base_reg    <= seg_base_next;
      seg_wen_reg     <= seg_wen_next;
      busy_reg        <= busy_next;
      drop_cnt_reg    <= drop_cnt_next;
      timeout_err_reg <= timeout_err_next;
      ovf_reg         <= ovf_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pend_data_next   = pend_data_reg;
    pend_base_next   = pend_base_reg;
    pend_vld_next    = pend_vld_reg;
    force_pend_next  = force_pend_reg;
    to_cnt_next      = to_cnt_reg;
    seg_data_next    = seg_data_reg;
    seg_base_next    = seg_base_reg;
    seg_wen_next     = 1'b0;
    ovf_next         = 1'b0;
    drop_cnt_next    = drop_cnt_reg;
    timeout_err_next = timeout_err_reg;
    issue            = 1'b0;

`ifdef SEG_UPD_CLAMP_EN
    {issue_ovf, issue_data} = clamp_value(pend_data_reg, pend_base_reg);
`else
    issue_data = pend_data_reg;
    issue_ovf  = 1'b0;
`endif

    case (state_reg)
      IDLE: begin
        // seg_rdy is sampled before every write so a wen is never lost.
        if (pend_vld_reg && seg_rdy && (ivl_ok || force_pend_reg)) begin
          issue         = 1'b1;
          seg_wen_next  = 1'b1;
          seg_data_next = issue_data;
          seg_base_next = pend_base_reg;
          ovf_next      = issue_ovf;
          to_cnt_next   = '0;
          state_next    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (seg_done) begin
          state_next = IDLE;
        end else if (to_cnt_reg == DONE_TIMEOUT - 16'd1) begin
          state_next       = IDLE;
          timeout_err_next = 1'b1;
        end else begin
          to_cnt_next = to_cnt_reg + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Buffer: a new update always wins; it is a drop only if it replaces a
    // value that was not issued this same cycle.
    if (in_valid) begin
      pend_data_next = in_data;
      pend_base_next = in_base;
      pend_vld_next  = 1'b1;
      if (pend_vld_reg && !issue && drop_cnt_reg != 16'hFFFF)
        drop_cnt_next = drop_cnt_reg + 16'd1;
    end else if (issue) begin
      pend_vld_next = 1'b0;
    end

    // A force pulse coinciding with an issue is kept for the following one.
    if (force_upd)  force_pend_next = 1'b1;
    else if (issue) force_pend_next = 1'b0;

    busy_next = (state_next == WAIT_DONE);
  end

  assign seg_data    = seg_data_reg;
  assign seg_base    = seg_base_reg;
  assign seg_wen     = seg_wen_reg;
  assign busy        = busy_reg;
  assign drop_cnt    = drop_cnt_reg;
  assign timeout_err = timeout_err_reg;
  assign ovf         = ovf_reg;

endmodule

// File: tb/tb_seg_update_ctrl.sv
// Directed bench for seg_update_ctrl with MIN_INTERVAL=8, DONE_TIMEOUT=16 and
// a display model: rdy drops on wen, done arrives 2 cycles after wen for hex
// and 10 for decimal, rdy returns the cycle after done.
module tb_seg_update_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_base = 1'b0;
  logic        in_valid = 1'b0;
  logic        force_upd = 1'b0;
  logic [31:0] seg_data;
  logic        seg_base;
  logic        seg_wen;
  logic        seg_rdy = 1'b1;
  logic        seg_done = 1'b0;
  logic        busy;
  logic [15:0] drop_cnt;
  logic        timeout_err;
  logic        ovf;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit withhold = 1'b0;
  int model_cnt = 0;

  seg_update_ctrl #(.MIN_INTERVAL(24'd8), .DONE_TIMEOUT(16'd16)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_base(in_base),
    .in_valid(in_valid), .force_upd(force_upd), .seg_data(seg_data),
    .seg_base(seg_base), .seg_wen(seg_wen), .seg_rdy(seg_rdy),
    .seg_done(seg_done), .busy(busy), .drop_cnt(drop_cnt),
    .timeout_err(timeout_err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Display model, updated 2 time units after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      seg_done = 1'b0;
      if (seg_wen) begin
        seg_rdy   = 1'b0;
        model_cnt = seg_base ? 10 : 2;
      end else if (model_cnt > 0) begin
        model_cnt = model_cnt - 1;
        if (model_cnt == 0) begin
          if (!withhold) seg_done = 1'b1;
          else seg_rdy = 1'b1;
        end
      end else if (!seg_rdy) begin
        seg_rdy = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic b, input logic f);
    in_data = d; in_base = b; in_valid = 1'b1; force_upd = f;
    step();
    in_valid = 1'b0; force_upd = 1'b0;
  endtask

  task automatic wait_wen(input int max, output bit seen, output int cycles);
    seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < max) begin
      step();
      cycles++;
      if (seg_wen) seen = 1'b1;
    end
  endtask

  task automatic wait_idle(input int max, output bit seen);
    int n = 0;
    seen = !busy;
    while (!seen && n < max) begin
      step();
      n++;
      if (!busy) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    total_cnt++;
    if (seg_data !== 32'd0 || seg_base !== 1'b0 || seg_wen !== 1'b0)
      $display("FAIL reset_seg: data=%h base=%b wen=%b required 0/0/0", seg_data, seg_base, seg_wen);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0 || drop_cnt !== 16'd0 || timeout_err !== 1'b0 || ovf !== 1'b0)
      $display("FAIL reset_status: busy=%b drop=%0d terr=%b ovf=%b required 0", busy, drop_cnt, timeout_err, ovf);
    else pass_cnt++;
    rst_n = 1'b1;
    step();
    $display("reset released");
  endtask

  task automatic test_basic();
    bit seen;
    send(32'h0012_3456, 1'b0, 1'b0);
    total_cnt++;
    if (seg_wen !== 1'b0) $display("FAIL basic_wen_t1: wen=%b required 0", seg_wen);
    else pass_cnt++;
    step();
    total_cnt++;
    if (seg_wen !== 1'b1) $display("FAIL basic_wen_t2: wen=%b required 1", seg_wen);
    else pass_cnt++;
    total_cnt++;
    if (seg_data !== 32'h0012_3456 || seg_base !== 1'b0)
      $display("FAIL basic_data: data=%h base=%b required 00123456/0", seg_data, seg_base);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL basic_busy: busy=%b required 1", busy);
    else pass_cnt++;
    step();
    total_cnt++;
    if (seg_wen !== 1'b0 || seg_data !== 32'h0012_3456)
      $display("FAIL basic_pulse: wen=%b data=%h required 0/00123456", seg_wen, seg_data);
    else pass_cnt++;
    wait_idle(10, seen);
    total_cnt++;
    if (!seen) $display("FAIL basic_done: busy=%b required 0 within 10 cycles", busy);
    else pass_cnt++;
    $display("basic write 00123456 issued");
  endtask

  task automatic test_drop();
    bit seen;
    int cyc;
    send(32'd1, 1'b0, 1'b0);
    send(32'd2, 1'b0, 1'b0);
    send(32'd3, 1'b0, 1'b0);
    wait_wen(20, seen, cyc);
    total_cnt++;
    if (!seen || seg_data !== 32'd3)
      $display("FAIL drop_value: seen=%b data=%h required 1/00000003", seen, seg_data);
    else pass_cnt++;
    total_cnt++;
    if (drop_cnt !== 16'd2) $display("FAIL drop_cnt: drop=%0d required 2", drop_cnt);
    else pass_cnt++;
    $display("latest-wins write issued after %0d cycles, drop_cnt=%0d", cyc, drop_cnt);
  endtask

  task automatic test_force();
    bit seen;
    int cyc;
    step();
    send(32'h55, 1'b0, 1'b1);
    wait_wen(10, seen, cyc);
    total_cnt++;
    if (!seen || cyc > 4)
      $display("FAIL force_early: seen=%b cycles=%0d required wen within 4 cycles", seen, cyc);
    else pass_cnt++;
    total_cnt++;
    if (seg_data !== 32'h55) $display("FAIL force_data: data=%h required 00000055", seg_data);
    else pass_cnt++;
    total_cnt++;
    if (drop_cnt !== 16'd2) $display("FAIL force_drop: drop=%0d required 2", drop_cnt);
    else pass_cnt++;
    $display("forced write issued after %0d cycles", cyc);
  endtask

  task automatic test_timeout();
    bit seen;
    int cyc;
    wait_idle(20, seen);
    repeat (12) step();
    withhold = 1'b1;
    send(32'h77, 1'b0, 1'b0);
    wait_wen(10, seen, cyc);
    repeat (10) step();
    total_cnt++;
    if (busy !== 1'b1 || timeout_err !== 1'b0)
      $display("FAIL tmo_wait: busy=%b terr=%b required 1/0", busy, timeout_err);
    else pass_cnt++;
    wait_idle(15, seen);
    total_cnt++;
    if (!seen || timeout_err !== 1'b1)
      $display("FAIL tmo_abort: idle=%b terr=%b required 1/1", seen, timeout_err);
    else pass_cnt++;
    withhold = 1'b0;
    repeat (12) step();
    send(32'h88, 1'b0, 1'b0);
    wait_wen(10, seen, cyc);
    total_cnt++;
    if (!seen || seg_data !== 32'h88)
      $display("FAIL tmo_next: seen=%b data=%h required 1/00000088", seen, seg_data);
    else pass_cnt++;
    total_cnt++;
    if (timeout_err !== 1'b1) $display("FAIL tmo_sticky: terr=%b required 1", timeout_err);
    else pass_cnt++;
    $display("timeout abort seen, next write 00000088 issued");
  endtask

  task automatic test_clamp();
    bit seen;
    int cyc;
    logic [31:0] exp_data;
    logic        exp_ovf;
`ifdef SEG_UPD_CLAMP_EN
    exp_data = 32'd999_999;
    exp_ovf  = 1'b1;
`else
    exp_data = 32'd1_234_567;
    exp_ovf  = 1'b0;
`endif
    wait_idle(20, seen);
    repeat (12) step();
    send(32'd1_234_567, 1'b1, 1'b0);
    wait_wen(10, seen, cyc);
    total_cnt++;
    if (!seen || seg_data !== exp_data || seg_base !== 1'b1)
      $display("FAIL clamp_data: seen=%b data=%0d base=%b required 1/%0d/1", seen, seg_data, seg_base, exp_data);
    else pass_cnt++;
    total_cnt++;
    if (ovf !== exp_ovf) $display("FAIL clamp_ovf: ovf=%b required %b", ovf, exp_ovf);
    else pass_cnt++;
    step();
    total_cnt++;
    if (ovf !== 1'b0) $display("FAIL clamp_ovf_pulse: ovf=%b required 0", ovf);
    else pass_cnt++;
    wait_idle(20, seen);
    total_cnt++;
    if (!seen || timeout_err !== 1'b1)
      $display("FAIL clamp_done: idle=%b terr=%b required 1/1", seen, timeout_err);
    else pass_cnt++;
    $display("decimal write issued, data=%0d ovf_required=%b", seg_data, exp_ovf);
  endtask

  task automatic test_reset_mid();
    bit seen;
    int cyc;
    repeat (12) step();
    send(32'h99, 1'b0, 1'b0);
    wait_wen(10, seen, cyc);
    send(32'hAA, 1'b0, 1'b0);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL rmid_pre: busy=%b required 1", busy);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (seg_wen !== 1'b0 || busy !== 1'b0 || seg_data !== 32'd0 || seg_base !== 1'b0)
      $display("FAIL rmid_outputs: wen=%b busy=%b data=%h base=%b required 0", seg_wen, busy, seg_data, seg_base);
    else pass_cnt++;
    total_cnt++;
    if (drop_cnt !== 16'd0 || timeout_err !== 1'b0 || ovf !== 1'b0)
      $display("FAIL rmid_status: drop=%0d terr=%b ovf=%b required 0", drop_cnt, timeout_err, ovf);
    else pass_cnt++;
    step(); step();
    rst_n = 1'b1;
    wait_wen(20, seen, cyc);
    total_cnt++;
    if (seen) $display("FAIL rmid_no_wen: wen seen after %0d cycles, required none", cyc);
    else pass_cnt++;
    send(32'hBB, 1'b0, 1'b0);
    wait_wen(10, seen, cyc);
    total_cnt++;
    if (!seen || seg_data !== 32'hBB)
      $display("FAIL rmid_new: seen=%b data=%h required 1/000000BB", seen, seg_data);
    else pass_cnt++;
    $display("reset during WAIT_DONE cleared buffer");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drop();
    test_force();
    test_timeout();
    test_clamp();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seg_update_ctrl.md
Name: seg_update_ctrl

Overview:
- Upstream feeder for the six-digit seven-segment display interface. It takes value updates from the application and drives the display's write handshake (data/wen/base in, rdy/done back).
- Provides a one-deep latest-value-wins buffer and rate-limits display writes to a minimum interval.
- Counts dropped updates and detects a display that never signals done.

Parameters:
- MIN_INTERVAL, 24'd4_999_999, clk cycles between successive issued writes (100 ms at 50 MHz).
- DONE_TIMEOUT, 16'd1023, max cycles in WAIT_DONE before abort.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- in_data  in  32  value to display
- in_base  in  1  1: decimal, 0: hexadecimal
- in_valid  in  1  one-cycle update strobe; always accepted
- force  in  1  pulse: next issue ignores MIN_INTERVAL
- seg_data  out  32  to display data
- seg_base  out  1  to display base
- seg_wen  out  1  to display wen, one-cycle pulse
- seg_rdy  in  1  display rdy
- seg_done  in  1  display done pulse
- busy  out  1  high in WAIT_DONE
- drop_cnt  out  16  overwritten-before-issued count, saturating at 16'hFFFF
- timeout_err  out  1  sticky; set on done timeout
- ovf  out  1  one-cycle clamp indication (see Optional Feature)

Behaviour:
- Reset values: seg_data=0, seg_base=0, seg_wen=0, busy=0, drop_cnt=0, timeout_err=0, ovf=0. Internal reset: pend_vld=0, force_pend=0, ivl_cnt=0, state=IDLE. All outputs are registered.
- Buffer:
  - When in_valid=1, pend_data/pend_base are loaded and pend_vld is set.
  - If pend_vld=1 and it is not consumed in the same cycle, drop_cnt increments (saturating).
  - If in_valid and consume occur in the same cycle, the new value is held, pend_vld stays 1, and no drop is counted.
- force: sets force_pend; force_pend is cleared on issue. force together with in_valid is legal.
- Interval: ivl_cnt loads MIN_INTERVAL on issue and decrements to 0, then holds. ivl_ok = (ivl_cnt==0).
- FSM:
  - IDLE: issue when pend_vld && seg_rdy && (ivl_ok || force_pend). On issue, next cycle: seg_wen=1 for exactly one cycle, seg_data/seg_base take the buffer, pend_vld clears (unless reloaded), state goes to WAIT_DONE, and the timeout counter clears.
  - WAIT_DONE: busy=1. On seg_done go to IDLE. If seg_done has not arrived after DONE_TIMEOUT cycles, go to IDLE and set timeout_err.
  - seg_data and seg_base stay stable from the wen cycle until the next issue.
- Display rdy is low for ≥1 cycle around done. The controller never pulses wen unless seg_rdy was sampled 1, so wen is never lost.
- Latency: in_valid at cycle t (IDLE, ivl_ok, seg_rdy=1) gives seg_wen=1 at t+2.
- seg_done while in IDLE is ignored.
- Async reset mid-WAIT_DONE: return to IDLE, discard the buffer, seg_wen=0 immediately.

Optional Feature:
- SEG_UPD_CLAMP_EN defined: at issue, values out of display range are clamped and ovf pulses with seg_wen.
  - Decimal (in_base=1) with in_data>999_999: issued value is 999_999.
  - Hex (in_base=0) with in_data>32'h00FF_FFFF: issued value is 32'h00FF_FFFF.
- Undefined: data passes unchanged (display truncates); ovf tied 0.

Decomposition:
- Package seg_pkg:
  - state encodings IDLE/WAIT_DONE
  - DEC_MAX=999_999, HEX_MAX=24'hFF_FFFF
  - DIGITS=6
- Sub-module seg_interval_timer: loadable saturating down counter, outputs ivl_ok.

Test Plan (MIN_INTERVAL=8, DONE_TIMEOUT=16, display model with done 2 cycles after wen for hex, 10 for decimal):
- in_valid in_data=32'h00123456 base=0 after reset -> seg_wen at t+2, seg_data=32'h00123456, seg_base=0, busy until done.
- Three in_valid strobes (1,2,3) during interval -> single next write of 3, drop_cnt=2.
- Second update 1 cycle after issue, with force pulse -> issued once seg_rdy=1, without waiting for ivl_cnt=0.
- Model withholds done -> after 16 cycles return to IDLE, timeout_err=1 persists, next update still issues.
- CLAMP_EN, base=1, in_data=1_234_567 -> seg_data=999_999, ovf=1 for one cycle. Undefined: seg_data=1_234_567, ovf=0.
- Reset asserted during WAIT_DONE with pend_vld=1 -> all outputs at reset values, no wen after release until new in_valid.
